// File: rtl/wrap_ptr_alloc_ctrl.sv
// wrap_ptr_alloc_ctrl
// Head/tail pointer owner for a SIZE-entry circular buffer. Grants up to
// MAX_OPS in-order allocations at the tail and retires up to MAX_OPS entries
// from the head each cycle. Pointers advance modulo SIZE, so SIZE need not
// be a power of two.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; clears all state immediately
//   alloc_num  entries requested this cycle (0..MAX_OPS)
//   alloc_gnt  combinational all-or-nothing grant (1 when alloc_num = 0)
//   alloc_idx  combinational slot indices, lane i = (tail + i) mod SIZE, lane 0 in LSBs
//   free_num   entries retired from the head this cycle
//   free_ok    combinational, 1 iff free_num <= count
//   flush      synchronous clear of head, tail and count (err is kept)
//   head       oldest valid entry
//   tail       next slot to allocate
//   count      valid entries, 0..SIZE
//   full       count == SIZE
//   empty      count == 0
//   err        sticky: over-free or a request above MAX_OPS
module wrap_ptr_alloc_ctrl #(
    parameter  int NBITS   = 2,
    parameter  int SIZE    = 4,
    parameter  int MAX_OPS = 2,
    localparam int OPW     = $clog2(MAX_OPS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OPW-1:0]           alloc_num,
    output logic                     alloc_gnt,
    output logic [MAX_OPS*NBITS-1:0] alloc_idx,
    input  logic [OPW-1:0]           free_num,
    output logic                     free_ok,
    input  logic                     flush,
    output logic [NBITS-1:0]         head,
    output logic [NBITS-1:0]         tail,
    output logic [NBITS:0]           count,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);

    localparam int CW = NBITS + 2;
    localparam logic [NBITS-1:0] LAST = NBITS'(SIZE - 1);

    logic [NBITS-1:0] head_q;
    logic [NBITS-1:0] tail_q;
    logic [NBITS:0]   count_q;
    logic             err_q;

    logic [NBITS-1:0] tail_adv;
    logic [NBITS-1:0] head_adv;
    logic [NBITS:0]   count_next;
    logic             alloc_bad;
    logic             free_bad;
    logic             alloc_fire;
    logic             free_fire;

    // Single wrap-around +1 stage.
    function automatic logic [NBITS-1:0] inc1(input logic [NBITS-1:0] p);
        return (p == LAST) ? '0 : p + NBITS'(1);
    endfunction

    // Tail chain: each +1 stage feeds one alloc_idx lane; the stage picked
    // by alloc_num becomes the advanced tail (stage 0 = pass-through).
    always_comb begin : tail_chain
        logic [NBITS-1:0] stage;
        stage     = tail_q;
        tail_adv  = tail_q;
        alloc_idx = '0;
        for (int unsigned i = 0; i < MAX_OPS; i++) begin
            alloc_idx[i*NBITS +: NBITS] = stage;
            stage = inc1(stage);
            if (alloc_num == OPW'(i + 1)) tail_adv = stage;
        end
    end

    always_comb begin : head_chain
        logic [NBITS-1:0] stage;
        stage    = head_q;
        head_adv = head_q;
        for (int unsigned i = 0; i < MAX_OPS; i++) begin
            stage = inc1(stage);
            if (free_num == OPW'(i + 1)) head_adv = stage;
        end
    end

    always_comb begin
        alloc_gnt  = CW'(alloc_num) <= (CW'(SIZE) - CW'(count_q));
        free_ok    = CW'(free_num) <= CW'(count_q);
        alloc_bad  = CW'(alloc_num) > CW'(MAX_OPS);
        free_bad   = CW'(free_num) > CW'(MAX_OPS);
        alloc_fire = alloc_gnt && (alloc_num != '0) && !alloc_bad;
        free_fire  = free_ok && (free_num != '0) && !free_bad;
        // Done modulo 2^(NBITS+1): truncation commutes with +/-, so this
        // equals the wider sum truncated, and the true result is in 0..SIZE.
        count_next = count_q
                   + (alloc_fire ? (NBITS+1)'(alloc_num) : '0)
                   - (free_fire  ? (NBITS+1)'(free_num)  : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_q | alloc_bad | free_bad | !free_ok;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (alloc_fire) tail_q <= tail_adv;
                if (free_fire)  head_q <= head_adv;
                count_q <= count_next;
            end
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign count = count_q;
    assign err   = err_q;
    assign full  = (count_q == (NBITS+1)'(SIZE));
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_wrap_ptr_alloc_ctrl.sv
module tb_wrap_ptr_alloc_ctrl;

    localparam int NBITS   = 2;
    localparam int SIZE    = 4;
    localparam int MAX_OPS = 2;
    localparam int OPW     = $clog2(MAX_OPS + 1);

    logic                     clk = 1'b0;
    logic                     reset;
    logic [OPW-1:0]           alloc_num;
    logic                     alloc_gnt;
    logic [MAX_OPS*NBITS-1:0] alloc_idx;
    logic [OPW-1:0]           free_num;
    logic                     free_ok;
    logic                     flush;
    logic [NBITS-1:0]         head;
    logic [NBITS-1:0]         tail;
    logic [NBITS:0]           count;
    logic                     full;
    logic                     empty;
    logic                     err;

    wrap_ptr_alloc_ctrl #(
        .NBITS  (NBITS),
        .SIZE   (SIZE),
        .MAX_OPS(MAX_OPS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .alloc_num(alloc_num),
        .alloc_gnt(alloc_gnt),
        .alloc_idx(alloc_idx),
        .free_num (free_num),
        .free_ok  (free_ok),
        .flush    (flush),
        .head     (head),
        .tail     (tail),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int head;
        int tail;
        int count;
        bit err;
    } exp_t;

    exp_t sb[$];

    int m_head  = 0;
    int m_tail  = 0;
    int m_count = 0;
    bit m_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ring invariant, checked every cycle away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b1)
            chk("invariant", 32'(tail), 32'((int'(head) + int'(count)) % SIZE));
    end

    // One cycle: drive, check combinational outputs against the model,
    // push expected post-edge state, then pop and compare after the edge.
    task automatic step(input int an, input int fn, input bit fl);
        exp_t e;
        exp_t got;
        bit   gnt_m, ok_m, a_fire, f_fire;
        logic [MAX_OPS*NBITS-1:0] idx_m;
        alloc_num = OPW'(an);
        free_num  = OPW'(fn);
        flush     = fl;
        #1;
        gnt_m = (an <= SIZE - m_count);
        ok_m  = (fn <= m_count);
        for (int i = 0; i < MAX_OPS; i++)
            idx_m[i*NBITS +: NBITS] = NBITS'((m_tail + i) % SIZE);
        chk("alloc_gnt", 32'(alloc_gnt), 32'(gnt_m));
        chk("free_ok", 32'(free_ok), 32'(ok_m));
        chk("alloc_idx", 32'(alloc_idx), 32'(idx_m));
        a_fire = gnt_m && an != 0 && an <= MAX_OPS;
        f_fire = ok_m && fn != 0 && fn <= MAX_OPS;
        m_err  = m_err | (an > MAX_OPS) | (fn > MAX_OPS) | !ok_m;
        if (fl) begin
            m_head = 0; m_tail = 0; m_count = 0;
        end else begin
            if (a_fire) begin m_tail = (m_tail + an) % SIZE; m_count += an; end
            if (f_fire) begin m_head = (m_head + fn) % SIZE; m_count -= fn; end
        end
        e.head = m_head; e.tail = m_tail; e.count = m_count; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        alloc_num = '0;
        free_num  = '0;
        flush     = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(0), 32'(1));
        end else begin
            got = sb.pop_front();
            chk("head", 32'(head), 32'(got.head));
            chk("tail", 32'(tail), 32'(got.tail));
            chk("count", 32'(count), 32'(got.count));
            chk("full", 32'(full), 32'(got.count == SIZE));
            chk("empty", 32'(empty), 32'(got.count == 0));
            chk("err", 32'(err), 32'(got.err));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        alloc_num = '0;
        free_num  = '0;
        flush     = 1'b0;
        #1;
        chk("rst_head", 32'(head), 32'(0));
        chk("rst_tail", 32'(tail), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_gnt", 32'(alloc_gnt), 32'(1));
        chk("rst_idx", 32'(alloc_idx), 32'h4);
        #11;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Fill: two allocs of 2, then a denied alloc at full.
        step(2, 0, 0);
        step(2, 0, 0);
        chk("tp_full", 32'(full), 32'(1));
        chk("tp_tail0", 32'(tail), 32'(0));
        step(1, 0, 0);
        chk("tp_denied_count", 32'(count), 32'(4));

        // Free from full with a same-cycle alloc that must be denied.
        step(1, 2, 0);
        chk("tp_head2", 32'(head), 32'(2));
        chk("tp_count2", 32'(count), 32'(2));

        // Wrap alloc then drain.
        step(2, 0, 0);
        chk("tp_wrap_tail", 32'(tail), 32'(2));
        step(0, 2, 0);
        step(0, 2, 0);
        chk("tp_drained", 32'(empty), 32'(1));

        // Reach head=3 tail=1 count=2, then simultaneous alloc 2 + free 1.
        step(1, 0, 0);
        step(0, 1, 0);
        step(2, 0, 0);
        step(2, 1, 0);
        chk("tp_sim_head", 32'(head), 32'(0));
        chk("tp_sim_tail", 32'(tail), 32'(3));
        chk("tp_sim_count", 32'(count), 32'(3));

        // Over-free, then flush (with a live alloc request) keeps err.
        step(0, 2, 0);
        step(0, 2, 0);
        chk("tp_overfree_err", 32'(err), 32'(1));
        chk("tp_overfree_head", 32'(head), 32'(2));
        step(2, 0, 1);
        chk("tp_flush_err", 32'(err), 32'(1));
        chk("tp_flush_count", 32'(count), 32'(0));

        // Build count=3, then async reset in the middle of a cycle.
        step(2, 0, 0);
        step(1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'(0));
        chk("arst_head", 32'(head), 32'(0));
        chk("arst_tail", 32'(tail), 32'(0));
        chk("arst_err", 32'(err), 32'(0));
        chk("arst_idx", 32'(alloc_idx), 32'h4);
        m_head = 0; m_tail = 0; m_count = 0; m_err = 1'b0;
        sb.delete();
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Requests above MAX_OPS are ignored and set err.
        step(3, 0, 0);
        step(1, 3, 0);
        step(2, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wrap_ptr_alloc_ctrl.md
# wrap_ptr_alloc_ctrl

Circular-buffer slot allocator that owns the head and tail pointers of a SIZE-entry ring (ROB, free list, issue queue) and sequences the wrap-around incrementers that advance them. Each cycle it grants up to MAX_OPS in-order allocations at the tail and retires up to MAX_OPS entries from the head. It also tracks occupancy, full and empty. Pointer advance is modulo SIZE, so non-power-of-two SIZE is legal.

## Interface
- NBITS, 2, pointer width; SIZE ≤ 2^NBITS
- SIZE, 4, ring entries
- MAX_OPS, 2, max allocs and max frees per cycle; OPW = clog2(MAX_OPS+1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- alloc_num  in  OPW  entries requested this cycle (0..MAX_OPS)
- alloc_gnt  out  1  combinational; 1 iff alloc_num ≤ SIZE − count (all-or-nothing); 1 when alloc_num = 0
- alloc_idx  out  MAX_OPS*NBITS  combinational; lane i = (tail + i) mod SIZE, lane 0 in LSBs; always driven
- free_num  in  OPW  entries retired from head this cycle
- free_ok  out  1  combinational; 1 iff free_num ≤ count
- flush  in  1  synchronous clear of head, tail and count; err is unaffected
- head  out  NBITS  oldest valid entry
- tail  out  NBITS  next slot to allocate
- count  out  NBITS+1  valid entries, 0..SIZE
- full  out  1  count == SIZE
- empty  out  1  count == 0
- err  out  1  sticky; set on an over-free or alloc_num/free_num > MAX_OPS

## Operation
- State registers: head, tail, count, err. All other outputs are derived from them.
- Wrap increment by k (0..MAX_OPS): k chained +1 stages, each mapping SIZE−1 → 0. Select stage k; k = 0 passes the value through.
- Alloc fires when alloc_gnt && alloc_num ≠ 0; then tail ← tail ⊕ alloc_num.
- Denied alloc: no state change. The requester holds the request and retries.
- Free fires when free_ok && free_num ≠ 0; then head ← head ⊕ free_num.
- Over-free (free_num > count): the free is ignored and err sets.
- Grant uses start-of-cycle count. Same-cycle frees do not create room for same-cycle allocs.
- Next count = count + (alloc fired ? alloc_num : 0) − (free fired ? free_num : 0). Compute at NBITS+2 bits, then truncate; the result never leaves 0..SIZE.
- Alloc and free in the same cycle both apply, independently.
- flush has priority over alloc and free: head = tail = count = 0 on the next edge. alloc_gnt and alloc_idx stay live during a flush cycle, but the grant is discarded.
- alloc_num or free_num > MAX_OPS: that operation is ignored and err sets.
- Invariant: tail == (head + count) mod SIZE. The bench asserts it every cycle.

## Timing
- Reset (reset = 0, asynchronous): head = tail = count = 0, err = 0, empty = 1, full = 0. With alloc_num = 0, alloc_gnt = 1 and alloc_idx = {1, 0}.
- Reset release is sampled on the next rising edge. The first op may be presented in the cycle after release.
- alloc_gnt, free_ok and alloc_idx settle combinationally in the request cycle. They are valid for use in that same cycle.
- Pointer, count, full, empty and err updates: 1-cycle latency, visible after the edge.
- Back-to-back ops are allowed every cycle. There is no bubble on wrap or at full/empty.
- Reset asserted mid-operation: in-flight grants are lost and state clears immediately. Nothing is committed from that cycle.

## Test plan
- Reset, then alloc_num = 2 for 2 cycles → alloc_idx {1,0} then {3,2}, both granted. Then tail = 0, count = 4, full = 1. A third alloc_num = 1 → alloc_gnt = 0, state unchanged.
- From full (head = 0), free_num = 2 with alloc_num = 1 in the same cycle → free applied, alloc denied. Next: head = 2, count = 2, tail = 0.
- Wrap: head = 2, tail = 0, count = 2, alloc_num = 2 → alloc_idx {1,0}. Next tail = 2, count = 4. Then free_num = 2 twice → head 0 then 2, empty = 1.
- Simultaneous: head = 3, tail = 1, count = 2, alloc 2 + free 1 → head = 0, tail = 3, count = 3.
- Over-free: count = 1, free_num = 2 → free_ok = 0, head unchanged, err = 1. err stays 1 through a later flush. flush clears pointers and count only.
- Asynchronous reset asserted mid-cycle with count = 3 → count, head, tail and err = 0 before the next edge. alloc_idx = {1,0} immediately.
